store_narrow_32x16: RTL and testbench

Store-path width adapter for the MIPS datapath: accepts one 32-bit store request (byte, halfword or word) from the memory stage and emits it as one or two little-endian halfword beats on a 16-bit data-memory bus with byte enables. It is the narrowing counterpart of the load-side 16-to-32 sign extension. It checks alignment, handshakes on both sides and signals completion or misalignment to the pipeline control.

---
 rtl/store_narrow_32x16.sv | 145 ++++++++++++++
 tb/tb_store_narrow_32x16.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_32x16.sv
// Purpose : store-path width adapter, one 32-bit byte/half/word store -> one or two 16-bit LE beats.
// Latency : accept at edge N -> first beat valid in cycle N+1; done pulses the cycle after the final beat.
// Backpres: req_ready only in IDLE; beats hold stable on the memory bus until mem_ready, never withdrawn.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             store request handshake
//   req_addr/req_data/req_size      byte address, right-justified data, size (00 b, 01 h, 10 w, 11 rsvd)
//   mem_valid/mem_ready             memory beat handshake
//   mem_addr/mem_data/mem_be        halfword-aligned beat address, beat data, byte enables
//   done                            one-cycle pulse: store finished on the bus
//   misalign                        one-cycle pulse: request rejected, no beats issued
module store_narrow_32x16 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic [1:0]        mem_be,
  output logic              done,
  output logic              misalign
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [1:0]        size;
  } req_t;

  logic [1:0] state_q, state_d;
  req_t       req_q, req_d;
  logic       done_q, done_d;
  logic       accept;
  logic       bad_align;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign done      = done_q;
  assign misalign  = (state_q == ST_ERR);
  assign mem_valid = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);

  // Alignment is judged on the live request so the ERR/BEAT0 choice is made at accept.
  always_comb begin
    bad_align = 1'b0;
    case (req_size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = req_addr[0];
      SZ_WORD: bad_align = |req_addr[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d.addr = req_addr;
          req_d.data = req_data;
          req_d.size = req_size;
          state_d    = bad_align ? ST_ERR : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          if (req_q.size == SZ_WORD) begin
            state_d = ST_BEAT1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;  // ST_ERR: single misalign cycle
    endcase
  end

  // Bus outputs are decoded from registered state only; zero outside a beat.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_be   = 2'b00;
    case (state_q)
      ST_BEAT0: begin
        mem_addr = {req_q.addr[ADDR_W-1:1], 1'b0};
        case (req_q.size)
          SZ_BYTE: begin
            // Byte is replicated on both lanes; the enable selects the live one.
            mem_data = {2{req_q.data[7:0]}};
            mem_be   = req_q.addr[0] ? 2'b10 : 2'b01;
          end
          default: begin
            mem_data = req_q.data[15:0];
            mem_be   = 2'b11;
          end
        endcase
      end
      ST_BEAT1: begin
        // Word is 4-byte aligned, so +2 is just setting bit 1 (no carry).
        mem_addr = {req_q.addr[ADDR_W-1:2], 2'b10};
        mem_data = req_q.data[31:16];
        mem_be   = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_store_narrow_32x16.sv
module tb_store_narrow_32x16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        done;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  store_narrow_32x16 #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
    .done(done), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b1;
    #12;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if ({done, misalign} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {done, misalign}); end
    checks++; if ({mem_addr, mem_data, mem_be} !== 50'd0) begin errors++; $display("FAIL reset_bus got=%h/%h/%b exp=0", mem_addr, mem_data, mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word();
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h1000; req_data = 32'hDEADBEEF; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, 32'h1000, 16'hBEEF, 2'b11})
      begin errors++; $display("FAIL word_beat0 got=%b %h %h %b exp=1 00001000 beef 11", mem_valid, mem_addr, mem_data, mem_be); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL word_busy_ready got=%b exp=0", req_ready); end
    tick();
    checks++; if ({mem_valid, mem_addr, mem_data, mem_be, done} !== {1'b1, 32'h1002, 16'hDEAD, 2'b11, 1'b0})
      begin errors++; $display("FAIL word_beat1 got=%b %h %h %b done=%b exp=1 00001002 dead 11 done=0", mem_valid, mem_addr, mem_data, mem_be, done); end
    tick();
    checks++; if ({mem_valid, done, req_ready} !== 3'b011)
      begin errors++; $display("FAIL word_done got=v%b d%b r%b exp=v0 d1 r1", mem_valid, done, req_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL word_done_width got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h2001; req_data = 32'h000000A5; req_size = 2'b00;
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, 32'h2000, 16'hA5A5, 2'b10})
      begin errors++; $display("FAIL byte_odd_beat got=%b %h %h %b exp=1 00002000 a5a5 10", mem_valid, mem_addr, mem_data, mem_be); end
    tick();
    checks++; if ({done, req_ready, mem_valid} !== 3'b110)
      begin errors++; $display("FAIL byte_odd_done got=d%b r%b v%b exp=d1 r1 v0", done, req_ready, mem_valid); end
    // Second request presented while done is high; accepted on this edge.
    req_valid = 1'b1; req_addr = 32'h2000;
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_valid, mem_addr, mem_data, mem_be, done} !== {1'b1, 32'h2000, 16'hA5A5, 2'b01, 1'b0})
      begin errors++; $display("FAIL byte_even_beat got=%b %h %h %b done=%b exp=1 00002000 a5a5 01 done=0", mem_valid, mem_addr, mem_data, mem_be, done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL byte_even_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_half_stall();
    int dones = 0;
    int hs = 0;
    mem_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h3002; req_data = 32'h00001234; req_size = 2'b01;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, 32'h3002, 16'h1234, 2'b11})
        begin errors++; $display("FAIL half_stall_c%0d got=%b %h %h %b exp=1 00003002 1234 11", i, mem_valid, mem_addr, mem_data, mem_be); end
      if (i == 3) mem_ready = 1'b1;
      if (mem_valid && mem_ready) hs++;
      if (done) dones++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (mem_valid && mem_ready) hs++;
      if (done) dones++;
      tick();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL half_handshakes got=%0d exp=1", hs); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL half_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3] = '{32'h4001, 32'h4002, 32'h4000};
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int vcnt = 0;
      int dcnt = 0;
      int mcnt = 0;
      req_valid = 1'b1; req_addr = addrs[k]; req_data = 32'h55AA55AA; req_size = sizes[k];
      tick();
      req_valid = 1'b0;
      checks++; if ({misalign, req_ready} !== 2'b10)
        begin errors++; $display("FAIL misalign_%0d_pulse got=m%b r%b exp=m1 r0", k, misalign, req_ready); end
      for (int c = 0; c < 3; c++) begin
        if (mem_valid) vcnt++;
        if (done) dcnt++;
        if (misalign) mcnt++;
        tick();
      end
      checks++; if ({vcnt, dcnt, mcnt} !== {32'd0, 32'd0, 32'd1})
        begin errors++; $display("FAIL misalign_%0d_counts got=v%0d d%0d m%0d exp=v0 d0 m1", k, vcnt, dcnt, mcnt); end
    end
  endtask

  task automatic test_high_addr();
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'hFFFFFFFC; req_data = 32'h13572468; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_valid, mem_addr, mem_data} !== {1'b1, 32'hFFFFFFFC, 16'h2468})
      begin errors++; $display("FAIL high_beat0 got=%b %h %h exp=1 fffffffc 2468", mem_valid, mem_addr, mem_data); end
    tick();
    checks++; if ({mem_valid, mem_addr, mem_data} !== {1'b1, 32'hFFFFFFFE, 16'h1357})
      begin errors++; $display("FAIL high_beat1 got=%b %h %h exp=1 fffffffe 1357", mem_valid, mem_addr, mem_data); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL high_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int dcnt = 0;
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h5000; req_data = 32'hCAFEF00D; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    checks++; if ({mem_valid, mem_addr} !== {1'b1, 32'h5002})
      begin errors++; $display("FAIL mid_in_beat1 got=%b %h exp=1 00005002", mem_valid, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_valid, req_ready, done} !== 3'b010)
      begin errors++; $display("FAIL mid_async_reset got=v%b r%b d%b exp=v0 r1 d0", mem_valid, req_ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", dcnt); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_back_to_back();
    test_half_stall();
    test_misalign();
    test_high_addr();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
